// File: rtl/accum_dispenser.sv
// accum_dispenser
//
// Drain side of the saturating accumulator path. A 16-bit total is loaded
// through a valid/ready handshake. The block then hands it to an 8-bit
// consumer as a stream of chunks. Every chunk is capped by a per-transfer
// maximum, and the chunks add up to the loaded total exactly.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load_valid    load request
//   load_ready    idle and able to accept a load
//   load_value    total to dispense
//   chunk_max     per-chunk cap, sampled at load (0 selects 2^OUT_W-1)
//   abort         cancel the current transfer
//   out_valid     chunk available
//   out_ready     consumer accepts chunk
//   out_data      chunk value
//   out_last      presented chunk is the final one
//   remaining     amount not yet handed over, including the presented chunk
//   busy          transfer in progress
//   done          one-cycle pulse after the final chunk is taken

`timescale 1ns/1ps

module accum_dispenser #(
    parameter int SUM_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [SUM_W-1:0] load_value,
    input  logic [OUT_W-1:0] chunk_max,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [SUM_W-1:0] remaining,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [OUT_W-1:0] CAP_MAX = '1;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] remaining_q, remaining_d;
    logic [OUT_W-1:0] cap_q, cap_d;
    logic             done_q, done_d;

    logic [SUM_W-1:0] capWide;
    logic [SUM_W-1:0] chunkWide;
    logic             lastChunk;

    // The presented chunk is min(remaining, cap). When the remainder fits
    // under the cap, that chunk is also the last one.
    always_comb begin
        capWide   = {{(SUM_W-OUT_W){1'b0}}, cap_q};
        lastChunk = (remaining_q <= capWide);
        chunkWide = lastChunk ? remaining_q : capWide;
    end

    // All outputs come from registered state. load_ready is also masked by
    // rst so that nothing can be loaded while reset is held.
    always_comb begin
        out_valid  = (state_q == SEND);
        busy       = (state_q == SEND);
        out_last   = (state_q == SEND) && lastChunk;
        out_data   = (state_q == SEND) ? chunkWide[OUT_W-1:0] : '0;
        load_ready = (state_q == IDLE) && !rst;
        remaining  = remaining_q;
        done       = done_q;
    end

    // Next-state logic. Abort takes priority over a coinciding handshake.
    // The consumer still keeps that chunk, but the counter is cleared and
    // no done pulse is raised.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cap_d       = cap_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid && load_ready) begin
                    remaining_d = load_value;
                    cap_d       = (chunk_max == '0) ? CAP_MAX : chunk_max;
                    if (load_value == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (out_ready) begin
                    remaining_d = remaining_q - chunkWide;
                    if (lastChunk) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. A reset mid-stream simply drops the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cap_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cap_q       <= cap_d;
            done_q      <= done_d;
        end
    end

endmodule
